mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of every port.
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive fetch-denied cycles before the fetch port is forced.
REQ-003 SHALL have ports (name  direction  width  meaning): clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have fetch ports: if_req in 1, if_addr in ADDR_W, if_gnt out 1, if_rvalid out 1, if_rdata out 32.
REQ-005 SHALL have data ports: d_req in 1, d_we in 1, d_be in 4, d_addr in ADDR_W, d_wdata in 32, d_gnt out 1, d_rvalid out 1, d_rdata out 32.
REQ-006 SHALL have loader/debug ports: dbg_lock in 1, dbg_req in 1, dbg_we in 1, dbg_addr in ADDR_W, dbg_wdata in 32, dbg_gnt out 1, dbg_rvalid out 1, dbg_rdata out 32.
REQ-007 SHALL have RAM ports: ram_en out 1, ram_we out 4, ram_addr out ADDR_W, ram_wdata out 32, ram_rdata in 32 (valid the cycle after a read enable).

Function
REQ-008 SHALL grant at most one requester per cycle; gnt is combinational from req and state, and a request is accepted in the cycle req&gnt is high.
REQ-009 SHALL use fixed priority dbg > data > fetch, except as modified by REQ-013 and REQ-014.
REQ-010 SHALL drive ram_en=1 and ram_addr/ram_wdata from the granted port in the grant cycle; ram_we = d_be if d_we, 4'hF if dbg_we, else 0.
REQ-011 SHALL, for a granted read, assert exactly that port's rvalid one cycle later with rdata = ram_rdata; writes produce no rvalid.
REQ-012 SHALL be fully pipelined: a new grant is allowed in the same cycle a previous read's rvalid is returned (one access per cycle sustained).
REQ-013 SHALL implement states RUN, DRAIN, LOCKED: RUN->DRAIN when dbg_lock rises with a read outstanding, RUN->LOCKED when none outstanding, DRAIN->LOCKED after the rvalid returns, LOCKED->RUN when dbg_lock falls.
REQ-014 SHALL, in DRAIN and LOCKED, grant neither fetch nor data; dbg port is grantable only in LOCKED and RUN.
REQ-015 SHALL hold rdata outputs at their last value when rvalid is low.
REQ-016 SHALL treat a requester deasserting req without gnt as a withdrawn request (no side effect).

Reset
REQ-017 SHALL, on rst_n low, asynchronously force state RUN, all gnt/rvalid/ram_en low, ram_we 0, rdata outputs 0, starvation counter 0, and discard any outstanding read.
REQ-018 SHALL NOT return rvalid after reset release for a read granted before reset.

Configuration
REQ-019 SHALL use macro MEM_ARB_STARVE_GUARD_EN: when defined, a counter increments each cycle if_req is high and if_gnt low, and at STARVE_MAX fetch beats data for one grant (counter clears on if_gnt); dbg still wins.
REQ-020 SHALL, without MEM_ARB_STARVE_GUARD_EN, use pure fixed priority and omit the counter.

Structure
REQ-021 SHALL place the state enum (RUN, DRAIN, LOCKED), the owner encoding (NONE, IF, D, DBG) and the write-all byte mask constant in the shared package.
REQ-022 SHALL be a single module; priority select is a function, no sub-module.

Verification
REQ-023 Only if_req, if_addr=0x40, ram_rdata=0x00000013 next cycle -> if_gnt=1 same cycle, if_rvalid=1 and if_rdata=0x00000013 one cycle later.
REQ-024 if_req and d_req (read 0x100) same cycle -> d_gnt=1, if_gnt=0; d_rvalid next cycle; fetch granted the following cycle.
REQ-025 d_req write d_be=4'b0011 d_wdata=0xAABBCCDD -> ram_we=4'b0011, no d_rvalid.
REQ-026 dbg_lock rises with a fetch read outstanding -> DRAIN, if_rvalid delivered, then LOCKED; dbg writes 0x0..0xC accepted back-to-back, if/d gnt low throughout; dbg_lock falls -> fetch granted next cycle.
REQ-027 With MEM_ARB_STARVE_GUARD_EN, STARVE_MAX=4, d_req and if_req held high -> if_gnt on 5th cycle, then d_gnt resumes; without the macro if_gnt never asserts.
REQ-028 rst_n pulsed low in the cycle after a data read grant -> d_rvalid stays 0, all outputs 0, normal grants resume after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, port-owner encoding, byte mask.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

  // Debug writes always store the full word.
  localparam logic [3:0] BE_ALL = 4'hF;

  // Fixed priority dbg > data > fetch; a starving fetch port jumps ahead of data only.
  function automatic owner_e prio_sel(
    input logic dbg_ok,
    input logic dbg_r,
    input logic d_ok,
    input logic d_r,
    input logic if_ok,
    input logic if_r,
    input logic if_force
  );
    owner_e sel;
    sel = OWN_NONE;
    if (dbg_ok && dbg_r)                 sel = OWN_DBG;
    else if (if_force && if_ok && if_r)  sel = OWN_IF;
    else if (d_ok && d_r)                sel = OWN_D;
    else if (if_ok && if_r)              sel = OWN_IF;
    return sel;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Three-port (fetch/data/debug) arbiter onto one single-cycle synchronous RAM.
// Latency: grant combinational in the request cycle; read data returned one cycle later.
// Backpressure: req held until gnt; one access per cycle sustained. Optional fetch
// starvation guard enabled by macro MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  // loader / debug port
  input  logic              dbg_lock,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  // RAM
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_e      state_q, state_d;
  owner_e      own;
  owner_e      rd_own_q, rd_own_d;
  logic        own_is_rd;
  logic        force_if;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_if = (starve_q >= CNT_W'(STARVE_MAX));

  // Count cycles the fetch port waits; saturate at the limit, clear when served.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt)
      starve_d = '0;
    else if (if_req && (starve_q < CNT_W'(STARVE_MAX)))
      starve_d = starve_q + CNT_W'(1);
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX != 0);
  assign force_if          = 1'b0;
`endif

  // Pick the owner of this cycle's RAM slot; nothing is granted while in reset.
  always_comb begin
    own = OWN_NONE;
    if (rst_n)
      own = prio_sel(state_q != ST_DRAIN, dbg_req,
                     state_q == ST_RUN,   d_req,
                     state_q == ST_RUN,   if_req,
                     force_if);
  end

  assign if_gnt  = (own == OWN_IF);
  assign d_gnt   = (own == OWN_D);
  assign dbg_gnt = (own == OWN_DBG);

  // Steer the granted port onto the RAM and note whether it is a read.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'h0;
    ram_addr  = '0;
    ram_wdata = '0;
    own_is_rd = 1'b0;
    case (own)
      OWN_IF: begin
        ram_en    = 1'b1;
        ram_addr  = if_addr;
        own_is_rd = 1'b1;
      end
      OWN_D: begin
        ram_en    = 1'b1;
        ram_we    = d_we ? d_be : 4'h0;
        ram_addr  = d_addr;
        ram_wdata = d_wdata;
        own_is_rd = !d_we;
      end
      OWN_DBG: begin
        ram_en    = 1'b1;
        ram_we    = dbg_we ? BE_ALL : 4'h0;
        ram_addr  = dbg_addr;
        ram_wdata = dbg_wdata;
        own_is_rd = !dbg_we;
      end
      default: ;
    endcase
  end

  assign rd_own_d = own_is_rd ? own : OWN_NONE;

  // Lock sequencing: a read issued in the lock-request cycle must drain before LOCKED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (dbg_lock) state_d = (rd_own_d != OWN_NONE) ? ST_DRAIN : ST_LOCKED;
      ST_DRAIN:  if (rd_own_q != OWN_NONE) state_d = ST_LOCKED;
      ST_LOCKED: if (!dbg_lock) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Return path: rvalid follows the read owner by one cycle; rdata holds when idle.
  assign if_rvalid  = (rd_own_q == OWN_IF);
  assign d_rvalid   = (rd_own_q == OWN_D);
  assign dbg_rvalid = (rd_own_q == OWN_DBG);

  assign if_rdata  = if_rvalid  ? ram_rdata : if_rdata_q;
  assign d_rdata   = d_rvalid   ? ram_rdata : d_rdata_q;
  assign dbg_rdata = dbg_rvalid ? ram_rdata : dbg_rdata_q;

  // Capture the visible rdata so it persists after rvalid drops.
  always_comb begin
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    dbg_rdata_d = dbg_rdata;
  end

  // FSM, outstanding-read owner and held rdata; reset discards any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      rd_own_q    <= OWN_NONE;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_own_q    <= rd_own_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-cycle grant/RAM expectations plus read responses.
// Latency: expectations pushed at issue, checked by a negedge monitor.
// Backpressure: n/a (bench drives requests directly).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        dbg_lock, dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .dbg_lock(dbg_lock), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // RAM model: fixed read contents, junk on non-read cycles so rdata hold is visible.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h0000_0013;
      32'h44:  return 32'h0000_0093;
      32'h48:  return 32'h0010_0073;
      32'h4C:  return 32'h0000_006F;
      32'h100: return 32'hCAFE_0100;
      32'h104: return 32'h1234_5678;
      32'h300: return 32'h0BAD_F00D;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_en && ram_we == 4'h0) ram_rdata <= rom(ram_addr);
    else                          ram_rdata <= 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [2:0]  gnt;   // {dbg,d,if}
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  rv;    // {dbg,d,if}
    string       name;
  } cyc_t;

  typedef struct {
    logic [2:0]  port;
    logic [31:0] data;
  } rsp_t;

  cyc_t exp_q[$];
  rsp_t rd_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Monitor: pops per-cycle expectations and read responses, tracks held rdata.
  logic [31:0] last_if = '0, last_d = '0, last_dbg = '0;
  always @(negedge clk) begin : mon
    cyc_t       e;
    rsp_t       r;
    logic [2:0] rv;
    rv = {dbg_rvalid, d_rvalid, if_rvalid};
    if (!rst_n) begin
      last_if = '0; last_d = '0; last_dbg = '0;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, " gnt/en/we/addr/wdata/rv"},
          {53'd0, dbg_gnt, d_gnt, if_gnt, ram_en, ram_we, ram_addr, ram_wdata, rv},
          {53'd0, e.gnt, e.en, e.we, e.addr, e.wdata, e.rv});
    end
    if (rv != 3'b000) begin
      if (rd_q.size() == 0) begin
        chk("unexpected_rvalid", {125'd0, rv}, 128'd0);
      end else begin
        r = rd_q.pop_front();
        chk("rsp_port", {125'd0, rv}, {125'd0, r.port});
        case (r.port)
          3'b001:  begin chk("if_rdata",  {96'd0, if_rdata},  {96'd0, r.data}); last_if  = r.data; end
          3'b010:  begin chk("d_rdata",   {96'd0, d_rdata},   {96'd0, r.data}); last_d   = r.data; end
          default: begin chk("dbg_rdata", {96'd0, dbg_rdata}, {96'd0, r.data}); last_dbg = r.data; end
        endcase
      end
    end
    if (!if_rvalid)  chk("if_rdata_hold",  {96'd0, if_rdata},  {96'd0, last_if});
    if (!d_rvalid)   chk("d_rdata_hold",   {96'd0, d_rdata},   {96'd0, last_d});
    if (!dbg_rvalid) chk("dbg_rdata_hold", {96'd0, dbg_rdata}, {96'd0, last_dbg});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push this cycle's expectation, then advance to the next cycle.
  task automatic expect_cyc(input logic [2:0] g, input logic en, input logic [3:0] we,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] rv, input string nm);
    cyc_t c;
    c.gnt = g; c.en = en; c.we = we; c.addr = a; c.wdata = wd; c.rv = rv; c.name = nm;
    exp_q.push_back(c);
    tick();
  endtask

  task automatic push_rsp(input logic [2:0] p, input logic [31:0] d);
    rsp_t r;
    r.port = p; r.data = d;
    rd_q.push_back(r);
  endtask

  task automatic idle_reqs();
    if_req = 0; d_req = 0; dbg_req = 0;
  endtask

  initial begin
    logic       is_if;
    logic [2:0] prv;
    rst_n = 0; dbg_lock = 0;
    if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h100; d_wdata = 32'h0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    // Reset: requests held high, everything must stay quiet.
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b000, "reset_state");
    rst_n = 1; idle_reqs();

    // Single fetch read.
    if_req = 1; if_addr = 32'h40;
    push_rsp(3'b001, 32'h0000_0013);
    expect_cyc(3'b001, 1, 4'h0, 32'h40, 32'h0, 3'b000, "fetch_grant");
    if_req = 0;
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b001, "fetch_rvalid");
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b000, "fetch_hold");

    // Data beats fetch; fetch served next cycle while data read returns.
    if_req = 1; if_addr = 32'h44;
    d_req = 1; d_we = 0; d_addr = 32'h100; d_wdata = 32'h1111_1111;
    push_rsp(3'b010, 32'hCAFE_0100);
    expect_cyc(3'b010, 1, 4'h0, 32'h100, 32'h1111_1111, 3'b000, "d_over_if");
    d_req = 0;
    push_rsp(3'b001, 32'h0000_0093);
    expect_cyc(3'b001, 1, 4'h0, 32'h44, 32'h0, 3'b010, "if_after_d");
    if_req = 0;
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b001, "if_after_d_rv");

    // Partial data write: byte mask passes through, no rvalid.
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hAABB_CCDD;
    expect_cyc(3'b010, 1, 4'b0011, 32'h200, 32'hAABB_CCDD, 3'b000, "d_write");
    d_req = 0; d_we = 0; d_be = 4'hF; d_wdata = 32'h0;
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b000, "d_write_no_rv");

    // All three request: dbg, then data, then fetch, back-to-back.
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h300;
    d_req = 1; d_addr = 32'h104;
    if_req = 1; if_addr = 32'h48;
    push_rsp(3'b100, 32'h0BAD_F00D);
    expect_cyc(3'b100, 1, 4'h0, 32'h300, 32'h0, 3'b000, "dbg_first");
    dbg_req = 0;
    push_rsp(3'b010, 32'h1234_5678);
    expect_cyc(3'b010, 1, 4'h0, 32'h104, 32'h0, 3'b100, "d_second");
    d_req = 0;
    push_rsp(3'b001, 32'h0010_0073);
    expect_cyc(3'b001, 1, 4'h0, 32'h48, 32'h0, 3'b010, "if_third");
    if_req = 0;
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b001, "prio_drain");

    // Lock raised together with a fetch read: DRAIN for one cycle, then LOCKED.
    if_req = 1; if_addr = 32'h4C; dbg_lock = 1;
    push_rsp(3'b001, 32'h0000_006F);
    expect_cyc(3'b001, 1, 4'h0, 32'h4C, 32'h0, 3'b000, "lock_req_fetch");
    d_req = 1; d_addr = 32'h100;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h0; dbg_wdata = 32'h1;
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b001, "drain_blocks_all");
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 32'(4 * i); dbg_wdata = 32'(i + 1);
      expect_cyc(3'b100, 1, 4'hF, 32'(4 * i), 32'(i + 1), 3'b000, "locked_dbg_wr");
    end
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; d_req = 0;
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b000, "unlock_cycle");
    push_rsp(3'b001, 32'h0000_006F);
    expect_cyc(3'b001, 1, 4'h0, 32'h4C, 32'h0, 3'b000, "fetch_after_unlock");
    if_req = 0;
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b001, "fetch_after_unlock_rv");

    // Data and fetch held: guard build lets fetch in on the 5th cycle.
    d_req = 1; d_we = 0; d_addr = 32'h100;
    if_req = 1; if_addr = 32'h40;
    prv = 3'b000;
    for (int i = 1; i <= 8; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      is_if = (i == 5);
`else
      is_if = 1'b0;
`endif
      if (is_if) begin
        push_rsp(3'b001, 32'h0000_0013);
        expect_cyc(3'b001, 1, 4'h0, 32'h40, 32'h0, prv, "starve_if");
        prv = 3'b001;
      end else begin
        push_rsp(3'b010, 32'hCAFE_0100);
        expect_cyc(3'b010, 1, 4'h0, 32'h100, 32'h0, prv, "starve_d");
        prv = 3'b010;
      end
    end
    idle_reqs();
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, prv, "starve_tail");
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b000, "starve_idle");

    // Reset pulse in the cycle after a data read grant: the read is dropped.
    d_req = 1; d_addr = 32'h100;
    expect_cyc(3'b010, 1, 4'h0, 32'h100, 32'h0, 3'b000, "pre_reset_grant");
    rst_n = 0; if_req = 1;
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b000, "in_reset");
    rst_n = 1; idle_reqs();
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b000, "post_reset_no_rv");
    d_req = 1; d_addr = 32'h104;
    push_rsp(3'b010, 32'h1234_5678);
    expect_cyc(3'b010, 1, 4'h0, 32'h104, 32'h0, 3'b000, "post_reset_grant");
    d_req = 0;
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b010, "post_reset_rv");
    expect_cyc(3'b000, 0, 4'h0, 32'h0, 32'h0, 3'b000, "final_idle");

    repeat (2) tick();
    chk("exp_q_empty", 128'(exp_q.size()), 128'd0);
    chk("rd_q_empty",  128'(rd_q.size()),  128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
